// File: rtl/ddr2_burst_sched.sv
// rtl/ddr2_burst_sched.sv - DDR2 ring-buffer burst scheduler (write/read arbitration)
// Optional round-robin arbitration: define DDR2_SCHED_RR_EN (default: fixed write priority).
module ddr2_burst_sched #(
    parameter int BL_LENGTH  = 8,
    parameter int ADDR_LIMIT = 2097152,
    parameter int WR_LEVEL   = 9
) (
    input  logic        phy_clk,
    input  logic        reset_phy_clk_n,
    input  logic        local_init_done,
    input  logic [13:0] wr_fifo_rdusedw,
    output logic        wr_fifo_rdreq,
    input  logic        rd_en,
    input  logic        local_ready,
    input  logic        local_rdata_valid,
    output logic [23:0] local_address,
    output logic        local_write_req,
    output logic        local_read_req,
    output logic        local_burstbegin,
    output logic [6:0]  local_size,
    output logic        rd_burst_done,
    output logic [21:0] fill,
    output logic        ring_full
);

    typedef enum logic [1:0] {IDLE, WR_BURST, RD_REQ, RD_WAIT} state_t;

    localparam int              BW        = (BL_LENGTH > 1) ? $clog2(BL_LENGTH) : 1;
    localparam logic [BW-1:0]   LAST_BEAT = BW'(BL_LENGTH - 1);
    localparam logic [23:0]     LAST_BASE = 24'(ADDR_LIMIT - BL_LENGTH);
    localparam logic [23:0]     BL_STEP   = 24'(BL_LENGTH);
    localparam logic [21:0]     FILL_MAX  = 22'(ADDR_LIMIT / BL_LENGTH);

    state_t        state_q, state_d;
    logic [BW-1:0] beat_cnt_q, beat_cnt_d;
    logic [23:0]   wr_addr_q, wr_addr_d;
    logic [23:0]   rd_addr_q, rd_addr_d;
    logic [21:0]   fill_q, fill_d;
    logic [23:0]   addr_q, addr_d;
    logic          wreq_q, wreq_d;
    logic          rreq_q, rreq_d;
    logic          bb_q, bb_d;
    logic          done_q, done_d;
    logic          wr_elig, rd_elig, full;
`ifdef DDR2_SCHED_RR_EN
    logic          last_grant_q, last_grant_d;  // 1 = read served last
`endif

    assign full    = (fill_q == FILL_MAX);
    assign wr_elig = local_init_done && (wr_fifo_rdusedw >= 14'(WR_LEVEL)) && !full;
    assign rd_elig = local_init_done && rd_en && (fill_q != '0);

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        fill_d     = fill_q;
        done_d     = 1'b0;
`ifdef DDR2_SCHED_RR_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef DDR2_SCHED_RR_EN
                if (wr_elig && rd_elig)
                    state_d = last_grant_q ? WR_BURST : RD_REQ;
                else if (wr_elig)
                    state_d = WR_BURST;
                else if (rd_elig)
                    state_d = RD_REQ;
`else
                if (wr_elig)
                    state_d = WR_BURST;
                else if (rd_elig)
                    state_d = RD_REQ;
`endif
            end
            WR_BURST: begin
                if (local_ready) begin
                    if (beat_cnt_q == LAST_BEAT) begin
                        beat_cnt_d = '0;
                        wr_addr_d  = (wr_addr_q == LAST_BASE) ? '0 : wr_addr_q + BL_STEP;
                        fill_d     = fill_q + 22'd1;
                        state_d    = IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            RD_REQ: begin
                if (local_ready) begin
                    rd_addr_d = (rd_addr_q == LAST_BASE) ? '0 : rd_addr_q + BL_STEP;
                    fill_d    = fill_q - 22'd1;
                    state_d   = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (local_rdata_valid) begin
                    if (beat_cnt_q == LAST_BEAT) begin
                        beat_cnt_d = '0;
                        done_d     = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef DDR2_SCHED_RR_EN
        if (state_q == IDLE && state_d == WR_BURST)
            last_grant_d = 1'b0;
        else if (state_q == IDLE && state_d == RD_REQ)
            last_grant_d = 1'b1;
`endif

        // Request outputs are decoded from next state so they register alongside it
        wreq_d = (state_d == WR_BURST);
        rreq_d = (state_d == RD_REQ);
        bb_d   = ((state_d == WR_BURST) && (beat_cnt_d == '0)) || (state_d == RD_REQ);
        case (state_d)
            WR_BURST: addr_d = wr_addr_d;
            RD_REQ:   addr_d = rd_addr_d;
            default:  addr_d = addr_q;
        endcase
    end

    always_ff @(posedge phy_clk) begin
        if (!reset_phy_clk_n) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            fill_q     <= '0;
            addr_q     <= '0;
            wreq_q     <= 1'b0;
            rreq_q     <= 1'b0;
            bb_q       <= 1'b0;
            done_q     <= 1'b0;
`ifdef DDR2_SCHED_RR_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            fill_q     <= fill_d;
            addr_q     <= addr_d;
            wreq_q     <= wreq_d;
            rreq_q     <= rreq_d;
            bb_q       <= bb_d;
            done_q     <= done_d;
`ifdef DDR2_SCHED_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign wr_fifo_rdreq    = wreq_q & local_ready;
    assign local_address    = addr_q;
    assign local_write_req  = wreq_q;
    assign local_read_req   = rreq_q;
    assign local_burstbegin = bb_q;
    assign local_size       = 7'(BL_LENGTH);
    assign rd_burst_done    = done_q;
    assign fill             = fill_q;
    assign ring_full        = full;

endmodule

// File: tb/tb_ddr2_burst_sched.sv
// tb/tb_ddr2_burst_sched.sv - scoreboard bench for ddr2_burst_sched (32-word ring)
module tb_ddr2_burst_sched;

    localparam int K_WR = 0, K_RD = 1, K_DONE = 2;

    typedef struct {
        int kind;
        int addr;
    } ev_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        init_done = 1'b0;
    logic [13:0] usedw = '0;
    logic        rdreq;
    logic        rd_en = 1'b0;
    logic        ready = 1'b0;
    logic        resp_valid = 1'b0;
    logic        stray_valid = 1'b0;
    logic        rvalid;
    logic [23:0] address;
    logic        write_req, read_req, burstbegin, done, full;
    logic [6:0]  size;
    logic [21:0] fill;

    int   vectors = 0;
    int   miscompares = 0;
    int   pops = 0;
    int   rbeats = 0;
    ev_t  exp_q[$];

    assign rvalid = resp_valid | stray_valid;

    always #5 clk = ~clk;

    ddr2_burst_sched #(.BL_LENGTH(8), .ADDR_LIMIT(32), .WR_LEVEL(9)) dut (
        .phy_clk           (clk),
        .reset_phy_clk_n   (resetn),
        .local_init_done   (init_done),
        .wr_fifo_rdusedw   (usedw),
        .wr_fifo_rdreq     (rdreq),
        .rd_en             (rd_en),
        .local_ready       (ready),
        .local_rdata_valid (rvalid),
        .local_address     (address),
        .local_write_req   (write_req),
        .local_read_req    (read_req),
        .local_burstbegin  (burstbegin),
        .local_size        (size),
        .rd_burst_done     (done),
        .fill              (fill),
        .ring_full         (full)
    );

    task automatic chk(input string name, input longint act, input longint req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input int kind, input int addr);
        ev_t e;
        e.kind = kind;
        e.addr = addr;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_grants(input int n);
        int seen = 0;
        int k = 0;
        while (seen < n && k < 200) begin
            tick();
            k++;
            if (burstbegin) seen++;
        end
        if (seen < n) chk("grant_timeout", seen, n);
    endtask

    task automatic wait_drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 500) begin
            tick();
            k++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    endtask

    // Monitor: every accepted burst start and every done pulse is matched against the scoreboard
    always @(negedge clk) begin
        ev_t e;
        if (rdreq) pops++;
        if (rvalid) rbeats++;
        if (resetn && burstbegin && ready && (write_req || read_req)) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_grant: got kind %0d addr %0d, expected none", read_req ? K_RD : K_WR, address);
            end else begin
                e = exp_q.pop_front();
                chk("grant_kind", read_req ? K_RD : K_WR, e.kind);
                chk("grant_addr", address, e.addr);
            end
            if (read_req) rbeats = 0;
        end
        if (resetn && done) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: got pulse, expected none");
            end else begin
                e = exp_q.pop_front();
                chk("done_kind", K_DONE, e.kind);
                chk("rd_beats", rbeats, 8);
            end
        end
    end

    // Read responder: 8 beats with one idle gap after each accepted read request
    always begin
        @(negedge clk);
        if (resetn && read_req && ready) begin
            for (int i = 0; i < 9; i++) begin
                @(posedge clk);
                #1;
                resp_valid = (i != 3);
            end
            @(posedge clk);
            #1;
            resp_valid = 1'b0;
        end
    end

    initial begin
        int p0;
        int bb;

        // Reset state
        init_done = 1'b1;
        usedw = 14'd20;
        ready = 1'b1;
        ticks(3);
        chk("rst_write_req", write_req, 0);
        chk("rst_read_req", read_req, 0);
        chk("rst_burstbegin", burstbegin, 0);
        chk("rst_done", done, 0);
        chk("rst_address", address, 0);
        chk("rst_fill", fill, 0);
        chk("rst_ring_full", full, 0);
        chk("rst_rdreq", rdreq, 0);
        chk("local_size", size, 8);

        // Two back-to-back write bursts at 0 and 8
        push(K_WR, 0);
        push(K_WR, 8);
        p0 = pops;
        resetn = 1'b1;
        tick();
        chk("wr1_req_latency", write_req, 1);
        chk("wr1_bb_first", burstbegin, 1);
        tick();
        chk("wr1_bb_second", burstbegin, 0);
        chk("wr1_req_held", write_req, 1);
        ticks(7);
        chk("wr1_fill", fill, 1);
        chk("wr1_idle_gap", write_req, 0);
        tick();
        chk("wr2_req", write_req, 1);
        chk("wr2_addr", address, 8);
        usedw = 14'd0;
        ticks(8);
        chk("wr2_fill", fill, 2);
        chk("wr2_end", write_req, 0);
        chk("wr12_pops", pops - p0, 16);
        ticks(2);
        chk("wr_no_more", write_req, 0);

        // Write burst at 16 with local_ready low for three beats mid-burst
        push(K_WR, 16);
        p0 = pops;
        usedw = 14'd20;
        tick();
        ticks(3);
        ready = 1'b0;
        bb = pops;
        ticks(3);
        chk("stall_addr", address, 16);
        chk("stall_req", write_req, 1);
        chk("stall_bb", burstbegin, 0);
        chk("stall_pops", pops - bb, 0);
        ready = 1'b1;
        usedw = 14'd0;
        ticks(5);
        chk("stall_total_pops", pops - p0, 8);
        chk("stall_fill", fill, 3);
        chk("stall_end", write_req, 0);

        // Fourth burst fills the 32-word ring and wraps the write pointer
        push(K_WR, 24);
        usedw = 14'd20;
        wait_grants(1);
        ticks(8);
        chk("full_fill", fill, 4);
        chk("full_flag", full, 1);
        bb = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (burstbegin || write_req) bb++;
        end
        chk("full_blocks_write", bb, 0);

        // Stray valid beats in IDLE, then two read-back bursts at 0 and 8
        usedw = 14'd0;
        stray_valid = 1'b1;
        ticks(2);
        stray_valid = 1'b0;
        push(K_RD, 0);
        push(K_DONE, 0);
        push(K_RD, 8);
        push(K_DONE, 0);
        rd_en = 1'b1;
        wait_grants(1);
        chk("rd1_req", read_req, 1);
        chk("rd1_addr", address, 0);
        chk("rd1_bb", burstbegin, 1);
        tick();
        chk("rd1_req_drop", read_req, 0);
        chk("rd1_fill", fill, 3);
        chk("rd1_not_full", full, 0);
        wait_grants(1);
        rd_en = 1'b0;
        wait_drain();
        ticks(3);
        chk("rd2_fill", fill, 2);

        // Contention: both classes eligible from the same cycle
`ifdef DDR2_SCHED_RR_EN
        push(K_WR, 0);
        push(K_RD, 16);
        push(K_DONE, 0);
`else
        push(K_WR, 0);
        push(K_WR, 8);
`endif
        usedw = 14'd20;
        rd_en = 1'b1;
        wait_grants(2);
        usedw = 14'd0;
        rd_en = 1'b0;
        wait_drain();
        ticks(12);
`ifdef DDR2_SCHED_RR_EN
        chk("cont_fill", fill, 2);
        chk("cont_full", full, 0);
`else
        chk("cont_fill", fill, 4);
        chk("cont_full", full, 1);
`endif

        // Reset in the middle of a write burst
        resetn = 1'b0;
        ticks(2);
        chk("rst2_fill", fill, 0);
        chk("rst2_full", full, 0);
        resetn = 1'b1;
        push(K_WR, 0);
        usedw = 14'd20;
        wait_grants(1);
        ticks(4);
        chk("midrst_req", write_req, 1);
        chk("midrst_addr", address, 0);
        resetn = 1'b0;
        tick();
        chk("midrst_write_req", write_req, 0);
        chk("midrst_bb", burstbegin, 0);
        chk("midrst_rdreq", rdreq, 0);
        chk("midrst_address", address, 0);
        chk("midrst_fill", fill, 0);
        usedw = 14'd0;
        p0 = pops;
        ticks(3);
        chk("midrst_no_pops", pops - p0, 0);
        resetn = 1'b1;
        ticks(3);
        chk("post_rst_idle", write_req, 0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
